// File: rtl/cu_pkg.sv
// Shared opcode constants, FSM state encoding, ALU select bit positions and
// instruction-class indices for the control unit.
package cu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_DIV_WAIT, ST_HALT
  } state_e;

  localparam int ALU_W      = 14;
  localparam int ALU_AND    = 0;
  localparam int ALU_OR     = 1;
  localparam int ALU_ADD    = 2;
  localparam int ALU_SUB    = 3;
  localparam int ALU_MUL    = 4;
  localparam int ALU_DIV    = 5;
  localparam int ALU_SHR    = 6;
  localparam int ALU_SHL    = 7;
  localparam int ALU_ROR    = 8;
  localparam int ALU_ROL    = 9;
  localparam int ALU_NEG    = 10;
  localparam int ALU_NOT    = 11;
  localparam int ALU_SHRA   = 12;
  localparam int ALU_BRANCH = 13;

  localparam int CLS_ALU_R = 0;
  localparam int CLS_ALU_I = 1;
  localparam int CLS_LD    = 2;
  localparam int CLS_LDI   = 3;
  localparam int CLS_ST    = 4;
  localparam int CLS_MUL   = 5;
  localparam int CLS_DIV   = 6;
  localparam int CLS_UNARY = 7;
  localparam int CLS_BR    = 8;
  localparam int CLS_JR    = 9;
  localparam int CLS_JAL   = 10;
  localparam int CLS_IN    = 11;
  localparam int CLS_OUT   = 12;
  localparam int CLS_NOP   = 13;
  localparam int CLS_HALT  = 14;
  localparam int CLS_W     = 15;

  function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
    return ALU_W'(1) << idx;
  endfunction

  // ALU operation an opcode requests in its compute step; zero when it has none.
  function automatic logic [ALU_W-1:0] op_alu_sel(input logic [OPC_W-1:0] opc);
    logic [ALU_W-1:0] sel;
    sel = '0;
    case (opc)
      OP_ADD, OP_ADDI: sel = alu_onehot(ALU_ADD);
      OP_SUB:          sel = alu_onehot(ALU_SUB);
      OP_AND, OP_ANDI: sel = alu_onehot(ALU_AND);
      OP_OR, OP_ORI:   sel = alu_onehot(ALU_OR);
      OP_SHR:          sel = alu_onehot(ALU_SHR);
      OP_SHRA:         sel = alu_onehot(ALU_SHRA);
      OP_SHL:          sel = alu_onehot(ALU_SHL);
      OP_ROR:          sel = alu_onehot(ALU_ROR);
      OP_ROL:          sel = alu_onehot(ALU_ROL);
      OP_MUL:          sel = alu_onehot(ALU_MUL);
      OP_DIV:          sel = alu_onehot(ALU_DIV);
      OP_NEG:          sel = alu_onehot(ALU_NEG);
      OP_NOT:          sel = alu_onehot(ALU_NOT);
      default:         sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps ir[31:27] to an instruction-class one-hot, the ALU
// operation that opcode uses, and an illegal-opcode flag.
module cu_decode
  import cu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic [CLS_W-1:0] cls_o,
  output logic [ALU_W-1:0] alu_op_o,
  output logic             illegal_o
);

  always_comb begin
    cls_o     = '0;
    illegal_o = 1'b0;
    alu_op_o  = op_alu_sel(opcode_i);
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        cls_o[CLS_ALU_R] = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI: cls_o[CLS_ALU_I] = 1'b1;
      OP_LD:                    cls_o[CLS_LD]    = 1'b1;
      OP_LDI:                   cls_o[CLS_LDI]   = 1'b1;
      OP_ST:                    cls_o[CLS_ST]    = 1'b1;
      OP_MUL:                   cls_o[CLS_MUL]   = 1'b1;
      OP_DIV:                   cls_o[CLS_DIV]   = 1'b1;
      OP_NEG, OP_NOT:           cls_o[CLS_UNARY] = 1'b1;
      OP_BR:                    cls_o[CLS_BR]    = 1'b1;
      OP_JR:                    cls_o[CLS_JR]    = 1'b1;
      OP_JAL:                   cls_o[CLS_JAL]   = 1'b1;
      OP_IN:                    cls_o[CLS_IN]    = 1'b1;
      OP_OUT:                   cls_o[CLS_OUT]   = 1'b1;
      OP_NOP:                   cls_o[CLS_NOP]   = 1'b1;
      OP_HALT:                  cls_o[CLS_HALT]  = 1'b1;
      default:                  illegal_o        = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hard-wired multi-cycle control unit: fetch T0-T2, per-class execute steps,
// divider wait with timeout, and a sticky fault for illegal opcodes/timeouts.
module control_unit
  import cu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             con,
  input  logic             div_done,
  output logic             PCout,
  output logic             MDRout,
  output logic             Zhighout,
  output logic             Zlowout,
  output logic             Cout,
  output logic             InPortout,
  output logic             BAout,
  output logic             PCin,
  output logic             IncPC,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             OutPortin,
  output logic             CONin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             Read,
  output logic             Write,
  output logic [ALU_W-1:0] alu_sel,
  output logic             div_rst,
  output logic             run,
  output logic             fault
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic [CLS_W-1:0]   cls;
  logic [ALU_W-1:0]   alu_op;
  logic               illegal;
  logic               unused_ir;

  assign unused_ir = ^ir[26:0];

  cu_decode u_decode (
    .opcode_i  (ir[31:27]),
    .cls_o     (cls),
    .alu_op_o  (alu_op),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
  assign run   = (state_q != ST_RST) && (state_q != ST_HALT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    PCout     = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    Cout      = 1'b0; InPortout = 1'b0; BAout = 1'b0;
    PCin      = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    Yin       = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    OutPortin = 1'b0; CONin = 1'b0;
    Gra       = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    Read      = 1'b0; Write = 1'b0;
    alu_sel   = '0;
    div_rst   = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        Read = 1'b1; MDRin = 1'b1;
        state_d = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        cnt_d = '0;
        if (illegal) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          case (1'b1)
            cls[CLS_ALU_R], cls[CLS_ALU_I]: begin
              Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = ST_T4;
            end
            cls[CLS_LD], cls[CLS_LDI], cls[CLS_ST]: begin
              Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = ST_T4;
            end
            cls[CLS_MUL]: begin
              Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = ST_T4;
            end
            cls[CLS_DIV]: begin
              Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; div_rst = 1'b1;
              state_d = ST_DIV_WAIT;
            end
            cls[CLS_UNARY]: begin
              Grb = 1'b1; Rout = 1'b1; alu_sel = alu_op; Zin = 1'b1; state_d = ST_T4;
            end
            cls[CLS_BR]: begin
              Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_d = ST_T4;
            end
            cls[CLS_JR]: begin
              Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_d = ST_T0;
            end
            cls[CLS_JAL]: begin
              PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; state_d = ST_T4;
            end
            cls[CLS_IN]: begin
              InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = ST_T0;
            end
            cls[CLS_OUT]: begin
              Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; state_d = ST_T0;
            end
            cls[CLS_HALT]: state_d = ST_HALT;
            default:       state_d = ST_T0;
          endcase
        end
      end
      ST_T4: begin
        state_d = ST_T0;
        case (1'b1)
          cls[CLS_ALU_R]: begin
            Grc = 1'b1; Rout = 1'b1; alu_sel = alu_op; Zin = 1'b1; state_d = ST_T5;
          end
          cls[CLS_ALU_I]: begin
            Cout = 1'b1; alu_sel = alu_op; Zin = 1'b1; state_d = ST_T5;
          end
          cls[CLS_LD], cls[CLS_LDI], cls[CLS_ST]: begin
            Cout = 1'b1; alu_sel = alu_onehot(ALU_ADD); Zin = 1'b1; state_d = ST_T5;
          end
          cls[CLS_MUL]: begin
            Grb = 1'b1; Rout = 1'b1; alu_sel = alu_op; Zin = 1'b1; state_d = ST_T5;
          end
          cls[CLS_UNARY]: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          cls[CLS_BR]: begin
            PCout = 1'b1; Yin = 1'b1; state_d = ST_T5;
          end
          cls[CLS_JAL]: begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_DIV_WAIT: begin
        Grb = 1'b1; Rout = 1'b1; alu_sel = alu_onehot(ALU_DIV);
        if (div_done) begin
          Zin = 1'b1;
          state_d = ST_T5;
        end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_T5: begin
        state_d = ST_T0;
        case (1'b1)
          cls[CLS_ALU_R], cls[CLS_ALU_I], cls[CLS_LDI]: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          cls[CLS_LD], cls[CLS_ST]: begin
            Zlowout = 1'b1; MARin = 1'b1; state_d = ST_T6;
          end
          cls[CLS_MUL], cls[CLS_DIV]: begin
            Zlowout = 1'b1; LOin = 1'b1; state_d = ST_T6;
          end
          cls[CLS_BR]: begin
            Cout = 1'b1; alu_sel = alu_onehot(ALU_ADD); Zin = 1'b1; state_d = ST_T6;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T6: begin
        state_d = ST_T0;
        case (1'b1)
          cls[CLS_LD]: begin
            Read = 1'b1; MDRin = 1'b1; state_d = ST_T7;
          end
          cls[CLS_ST]: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = ST_T7;
          end
          cls[CLS_MUL], cls[CLS_DIV]: begin
            Zhighout = 1'b1; HIin = 1'b1;
          end
          cls[CLS_BR]: begin
            Zlowout = con; PCin = con;
          end
          default: state_d = ST_T0;
        endcase
      end
      ST_T7: begin
        state_d = ST_T0;
        if (cls[CLS_LD]) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls[CLS_ST]) begin
          Write = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: expected strobe sequences come from a per-opcode table
// of the documented step lists, driven with randomized con/div_done noise.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        con = 1'b0;
  logic        div_done = 1'b0;
  logic PCout, MDRout, Zhighout, Zlowout, Cout, InPortout, BAout;
  logic PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, Read, Write, div_rst, run, fault;
  logic [13:0] alu_sel;
  logic [39:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  control_unit #(.DIV_TIMEOUT(40)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con), .div_done(div_done),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .Cout(Cout), .InPortout(InPortout), .BAout(BAout),
    .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Read(Read), .Write(Write), .alu_sel(alu_sel), .div_rst(div_rst),
    .run(run), .fault(fault)
  );

  assign obs = {div_rst, alu_sel, Read, Write, Gra, Grb, Grc, Rin, Rout,
                PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                OutPortin, CONin, PCout, MDRout, Zhighout, Zlowout, Cout,
                InPortout, BAout};

  localparam logic [39:0] M_BAout = 40'd1 << 0,  M_InPortout = 40'd1 << 1;
  localparam logic [39:0] M_Cout = 40'd1 << 2,   M_Zlowout = 40'd1 << 3;
  localparam logic [39:0] M_Zhighout = 40'd1 << 4, M_MDRout = 40'd1 << 5;
  localparam logic [39:0] M_PCout = 40'd1 << 6,  M_CONin = 40'd1 << 7;
  localparam logic [39:0] M_OutPortin = 40'd1 << 8, M_LOin = 40'd1 << 9;
  localparam logic [39:0] M_HIin = 40'd1 << 10,  M_Zin = 40'd1 << 11;
  localparam logic [39:0] M_Yin = 40'd1 << 12,   M_MDRin = 40'd1 << 13;
  localparam logic [39:0] M_MARin = 40'd1 << 14, M_IRin = 40'd1 << 15;
  localparam logic [39:0] M_IncPC = 40'd1 << 16, M_PCin = 40'd1 << 17;
  localparam logic [39:0] M_Rout = 40'd1 << 18,  M_Rin = 40'd1 << 19;
  localparam logic [39:0] M_Grc = 40'd1 << 20,   M_Grb = 40'd1 << 21;
  localparam logic [39:0] M_Gra = 40'd1 << 22,   M_Write = 40'd1 << 23;
  localparam logic [39:0] M_Read = 40'd1 << 24,  M_div_rst = 40'd1 << 39;
  localparam logic [39:0] A_AND = 40'd1 << 25, A_OR = 40'd1 << 26, A_ADD = 40'd1 << 27;
  localparam logic [39:0] A_SUB = 40'd1 << 28, A_MUL = 40'd1 << 29, A_DIV = 40'd1 << 30;
  localparam logic [39:0] A_SHR = 40'd1 << 31, A_SHL = 40'd1 << 32, A_ROR = 40'd1 << 33;
  localparam logic [39:0] A_ROL = 40'd1 << 34, A_NEG = 40'd1 << 35, A_NOT = 40'd1 << 36;
  localparam logic [39:0] A_SHRA = 40'd1 << 37;

  function automatic logic [39:0] aop(input int op);
    case (op)
      3, 12:  return A_ADD;
      4:      return A_SUB;
      5, 13:  return A_AND;
      6, 14:  return A_OR;
      7:      return A_SHR;
      8:      return A_SHRA;
      9:      return A_SHL;
      10:     return A_ROR;
      11:     return A_ROL;
      15:     return A_MUL;
      16:     return A_DIV;
      17:     return A_NEG;
      18:     return A_NOT;
      default: return 40'd0;
    endcase
  endfunction

  // Expected strobe set per cycle from T0 up to (not including) the next T0.
  // k = cycle of DIV_WAIT on which div_done rises; k = 0 means it never does.
  task automatic build(input int op, input logic c, input int k);
    exp_q.delete();
    exp_q.push_back(M_PCout | M_MARin | M_IncPC);
    exp_q.push_back(M_Read | M_MDRin);
    exp_q.push_back(M_MDRout | M_IRin);
    if (op >= 3 && op <= 14) begin
      exp_q.push_back(M_Grb | M_Rout | M_Yin);
      if (op <= 11) exp_q.push_back(M_Grc | M_Rout | aop(op) | M_Zin);
      else          exp_q.push_back(M_Cout | aop(op) | M_Zin);
      exp_q.push_back(M_Zlowout | M_Gra | M_Rin);
    end else if (op <= 2) begin
      exp_q.push_back(M_Grb | M_Rout | M_BAout | M_Yin);
      exp_q.push_back(M_Cout | A_ADD | M_Zin);
      if (op == 1) exp_q.push_back(M_Zlowout | M_Gra | M_Rin);
      else begin
        exp_q.push_back(M_Zlowout | M_MARin);
        if (op == 0) begin
          exp_q.push_back(M_Read | M_MDRin);
          exp_q.push_back(M_MDRout | M_Gra | M_Rin);
        end else begin
          exp_q.push_back(M_Gra | M_Rout | M_MDRin);
          exp_q.push_back(M_Write);
        end
      end
    end else if (op == 15 || op == 16) begin
      if (op == 15) begin
        exp_q.push_back(M_Gra | M_Rout | M_Yin);
        exp_q.push_back(M_Grb | M_Rout | A_MUL | M_Zin);
      end else begin
        exp_q.push_back(M_Gra | M_Rout | M_Yin | M_div_rst);
        for (int j = 1; j <= ((k == 0) ? 40 : k); j++)
          exp_q.push_back(M_Grb | M_Rout | A_DIV | ((j == k) ? M_Zin : 40'd0));
      end
      if (!(op == 16 && k == 0)) begin
        exp_q.push_back(M_Zlowout | M_LOin);
        exp_q.push_back(M_Zhighout | M_HIin);
      end
    end else if (op == 17 || op == 18) begin
      exp_q.push_back(M_Grb | M_Rout | aop(op) | M_Zin);
      exp_q.push_back(M_Zlowout | M_Gra | M_Rin);
    end else if (op == 19) begin
      exp_q.push_back(M_Gra | M_Rout | M_CONin);
      exp_q.push_back(M_PCout | M_Yin);
      exp_q.push_back(M_Cout | A_ADD | M_Zin);
      exp_q.push_back(c ? (M_Zlowout | M_PCin) : 40'd0);
    end else if (op == 20) exp_q.push_back(M_Gra | M_Rout | M_PCin);
    else if (op == 21) begin
      exp_q.push_back(M_PCout | M_Grb | M_Rin);
      exp_q.push_back(M_Gra | M_Rout | M_PCin);
    end else if (op == 22) exp_q.push_back(M_InPortout | M_Gra | M_Rin);
    else if (op == 23) exp_q.push_back(M_Gra | M_Rout | M_OutPortin);
    else exp_q.push_back(40'd0);  // nop, halt and illegal opcodes: empty T3
  endtask

  // Drives one instruction from its T0; ncyc < 0 runs the whole sequence.
  task automatic run_instr(input int op, input logic [26:0] fields, input logic c,
                           input int k, input int ncyc);
    int n;
    build(op, c, k);
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ir = {5'(op), fields};
      con = (op == 19 && i == 6) ? c : 1'($urandom);
      if (op == 16 && i >= 4 && (k == 0 || i <= 3 + k))
        div_done = (k != 0 && i == 3 + k);
      else
        div_done = 1'($urandom);
      #1;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL strobes op=%05b cyc=%0d: got %h expected %h", 5'(op), i, obs, exp_q[i]);
      end
      n_checks++;
      if (run !== 1'b1) begin
        n_fail++;
        $display("FAIL run op=%05b cyc=%0d: got %b expected 1", 5'(op), i, run);
      end
      n_checks++;
      if (fault !== 1'b0) begin
        n_fail++;
        $display("FAIL fault op=%05b cyc=%0d: got %b expected 0", 5'(op), i, fault);
      end
    end
    $display("instr op=%05b con=%b k=%0d cycles=%0d", 5'(op), c, k, n);
  endtask

  task automatic check_halt(input string name, input logic exp_fault);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      con = 1'($urandom); div_done = 1'($urandom); ir = $urandom;
      #1;
      n_checks++;
      if (obs !== 40'd0 || run !== 1'b0 || fault !== exp_fault) begin
        n_fail++;
        $display("FAIL %s halt: strobes=%h run=%b fault=%b expected strobes=0 run=0 fault=%b",
                 name, obs, run, fault, exp_fault);
      end
    end
    $display("%s: HALT held, fault=%b", name, fault);
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs !== 40'd0 || run !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: strobes=%h run=%b fault=%b expected all 0", obs, run, fault);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== 40'd0 || run !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: strobes=%h run=%b expected 0/0", obs, run);
    end
    $display("reset: done");
  endtask

  task automatic test_add();
    run_instr(3, {4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 0, -1);
    run_instr(26, 27'd0, 1'b0, 0, -1);  // its T0 lands on the 7th edge
  endtask

  task automatic test_ld_st();
    run_instr(0, 27'($urandom), 1'b0, 0, -1);
    run_instr(1, 27'($urandom), 1'b0, 0, -1);
    run_instr(2, 27'($urandom), 1'b0, 0, -1);
  endtask

  task automatic test_div();
    run_instr(16, 27'($urandom), 1'b0, 5, -1);
    run_instr(16, 27'($urandom), 1'b0, 1, -1);
    run_instr(16, 27'($urandom), 1'b0, 40, -1);
    run_instr(26, 27'd0, 1'b0, 0, -1);
  endtask

  task automatic test_div_timeout();
    run_instr(16, 27'($urandom), 1'b0, 0, -1);
    check_halt("div_timeout", 1'b1);
    test_reset();
  endtask

  task automatic test_br();
    run_instr(19, 27'($urandom), 1'b0, 0, -1);
    run_instr(19, 27'($urandom), 1'b1, 0, -1);
    run_instr(26, 27'd0, 1'b0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr(31, 27'($urandom), 1'b0, 0, -1);
    check_halt("illegal_11111", 1'b1);
    test_reset();
    run_instr(24 + 5'($urandom_range(0, 1)), 27'd0, 1'b0, 0, -1);
    check_halt("illegal_1100x", 1'b1);
    test_reset();
    run_instr(27, 27'd0, 1'b0, 0, -1);
    check_halt("halt_op", 1'b0);
    test_reset();
  endtask

  task automatic test_clr_mid_mul();
    run_instr(15, 27'($urandom), 1'b0, 0, 5);  // stop inside T4
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if (obs !== 40'd0 || run !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_mid_mul: strobes=%h run=%b fault=%b expected all 0", obs, run, fault);
    end
    @(negedge clk);
    clr = 1'b0;
    $display("clr_mid_mul: async clear applied");
    run_instr(3, 27'($urandom), 1'b0, 0, -1);
  endtask

  task automatic test_back_to_back();
    int ops[25];
    for (int i = 0; i < 24; i++) ops[i] = i;
    ops[24] = 26;
    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 24)], 27'($urandom), 1'($urandom),
                $urandom_range(1, 12), -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ld_st();
    test_div();
    test_br();
    test_back_to_back();
    test_div_timeout();
    test_illegal();
    test_clr_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter DIV_TIMEOUT, default 40; maximum cycles spent in DIV_WAIT before a fault halt.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 clr  in  1  reset; asynchronous, active-high.
REQ-004 ir  in  32  IR contents; opcode ir[31:27].
REQ-005 con  in  1  CON flip-flop result.
REQ-006 div_done  in  1  divider result valid.
REQ-007 PCout, MDRout, Zhighout, Zlowout, Cout, InPortout, BAout  out  1 each  bus-source strobes.
REQ-008 PCin, IncPC, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin, CONin  out  1 each  register-load strobes.
REQ-009 Gra, Grb, Grc, Rin, Rout  out  1 each  register-select controls.
REQ-010 Read, Write  out  1 each  RAM controls.
REQ-011 alu_sel  out  14  one-hot ALU op, bit order {BRANCH,SHRA,NOT,NEG,ROL,ROR,SHL,SHR,DIV,MUL,SUB,ADD,OR,AND}.
REQ-012 div_rst  out  1  divider restart pulse.
REQ-013 run  out  1  high while fetching/executing.
REQ-014 fault  out  1  sticky; illegal opcode or divide timeout.

Function
REQ-015 States: RST, T0-T7, DIV_WAIT, HALT; strobes decode combinationally from state, opcode, con, div_done.
REQ-016 Only the strobes listed for a state are 1; all others are 0.
REQ-017 Fetch: T0 PCout,MARin,IncPC; T1 Read,MDRin; T2 MDRout,IRin; T2->T3 always.
REQ-018 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, nop 11010, halt 11011.
REQ-019 R-format: T3 Grb,Rout,Yin; T4 Grc,Rout,op,Zin; T5 Zlowout,Gra,Rin -> T0.
REQ-020 Immediate (addi/andi/ori): as R-format but T4 Cout replaces Grc,Rout.
REQ-021 ld/ldi: T3 Grb,Rout,BAout,Yin; T4 Cout,ADD,Zin; ldi T5 Zlowout,Gra,Rin; ld T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-022 st: T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write -> T0.
REQ-023 mul: T3 Gra,Rout,Yin; T4 Grb,Rout,MUL,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
REQ-024 div: T3 Gra,Rout,Yin,div_rst; DIV_WAIT Grb,Rout,DIV each cycle; Zin only in the cycle div_done=1, then T5/T6 as mul.
REQ-025 DIV_WAIT cycle counter; count reaching DIV_TIMEOUT without div_done -> HALT, fault=1.
REQ-026 neg/not: T3 Grb,Rout,op,Zin; T4 Zlowout,Gra,Rin.
REQ-027 br: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout,PCin only if con=1; T0 either way.
REQ-028 jr: T3 Gra,Rout,PCin. jal: T3 PCout,Grb,Rin; T4 Gra,Rout,PCin.
REQ-029 in: T3 InPortout,Gra,Rin. out: T3 Gra,Rout,OutPortin. nop: T3 no strobes.
REQ-030 halt -> HALT; undefined opcode -> HALT with fault=1; HALT holds all strobes 0, run=0, until clr.
REQ-031 con sampled only in br T6; div_done ignored outside DIV_WAIT.

Reset
REQ-032 clr=1 forces state RST, counter 0, fault 0, run 0, all strobes 0, regardless of clock or any in-flight instruction or divide.
REQ-033 First edge after clr falls: RST->T0, run=1.

Structure
REQ-034 Package cu_pkg holds opcode constants, state encoding, alu_sel bit indices.
REQ-035 One sub-module cu_decode: ir[31:27] -> instruction-class one-hot plus illegal flag.

Verification
REQ-036 Reset, ir=add R1,R2,R3: T0 PCout,MARin,IncPC; T5 Zlowout,Gra,Rin; back at T0 on the 7th edge.
REQ-037 ld: T5 MARin, T6 Read, T7 MDRout,Gra,Rin; st: T6 Read=0 with MDRin, T7 Write=1.
REQ-038 div, div_done asserted on 5th DIV_WAIT cycle: Zin=1 only that cycle, then LOin, HIin, T0; div_done withheld 40 cycles: HALT, fault=1.
REQ-039 br with con=0 vs con=1 at T6: PCin 0 vs 1; both return to T0.
REQ-040 ir opcode 11111 -> HALT, fault=1, run=0; clr pulse mid-T4 of mul -> all strobes 0 immediately, fetch restarts.
